rom_boot_ctrl: RTL and testbench

ROM_BOOT_CTRL -- requirements
Module: rom_boot_ctrl

---
 rtl/rom_boot_ctrl_if.sv | 38 +++
 rtl/rom_boot_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rom_boot_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_boot_ctrl_if.sv
// ---------------------------------------------------------------------------
// rom_boot_ctrl_if
// Bundles the boot controller's three conversations into one interface:
//   loader stream : ld_valid, ld_data, ld_last in; ld_ready out
//   ROM port      : rom_write_enable, rom_addr, rom_wdata, rom_read_enable out
//   CPU port      : cpu_addr, cpu_read_enable, cpu_halt in; cpu_reset, cpu_go out
// The master modport is the controller itself. The slave modport is the
// surrounding loader / ROM / CPU environment.
// ---------------------------------------------------------------------------
interface rom_boot_ctrl_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;

  logic        rom_write_enable;
  logic [31:0] rom_addr;
  logic [31:0] rom_wdata;
  logic        rom_read_enable;

  logic [31:0] cpu_addr;
  logic        cpu_read_enable;
  logic        cpu_halt;
  logic        cpu_reset;
  logic        cpu_go;

  modport master (
    input  ld_valid, ld_data, ld_last, cpu_addr, cpu_read_enable, cpu_halt,
    output ld_ready, rom_write_enable, rom_addr, rom_wdata, rom_read_enable,
           cpu_reset, cpu_go
  );

  modport slave (
    output ld_valid, ld_data, ld_last, cpu_addr, cpu_read_enable, cpu_halt,
    input  ld_ready, rom_write_enable, rom_addr, rom_wdata, rom_read_enable,
           cpu_reset, cpu_go
  );
endinterface

// File: rtl/rom_boot_ctrl.sv
// ---------------------------------------------------------------------------
// rom_boot_ctrl
// Streams a program from a loader into the instruction ROM. It appends a
// zero terminator word unless the ROM filled up. It then holds the CPU in
// reset for RESET_HOLD cycles before letting it run. While the CPU runs, the
// ROM address and read strobe are handed straight through to the CPU.
//
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   start       : begin a (re)load; only honoured when idle or halted
//   bus         : loader / ROM / CPU signals (rom_boot_ctrl_if.master)
//   load_count  : words written by the last load, terminator excluded
//   err_full    : sticky, set when the ROM filled without ld_last
//   done        : high while the CPU is halted
// ---------------------------------------------------------------------------
module rom_boot_ctrl #(
  parameter int DEPTH      = 32,
  parameter int RESET_HOLD = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  rom_boot_ctrl_if.master        bus,
  output logic [8:0]             load_count,
  output logic                   err_full,
  output logic                   done
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]  LastPtr  = PW'(DEPTH - 1);
  localparam logic [3:0]     HoldLast = 4'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TERM,
    RELEASE,
    RUN,
    HALTED
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [8:0]    load_count_q, load_count_d;
  logic          err_full_q, err_full_d;
  logic [3:0]    hold_q, hold_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic [31:0]   ptr_addr;

  // Byte address of the word slot the write pointer currently names.
  assign ptr_addr = {{(30 - PW){1'b0}}, wr_ptr_q, 2'b00};

  assign load_count = load_count_q;
  assign err_full   = err_full_q;

  // All state registers. Reset also drops any ROM write that was staged on
  // the same edge, so an aborted load never lands a stray word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      err_full_q   <= 1'b0;
      hold_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      err_full_q   <= err_full_d;
      hold_q       <= hold_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Next-state and output decode.
  // ROM writes are staged into wr_*_q, so every accepted word appears on the
  // ROM port one cycle after its handshake. Outside RUN the ROM port shows
  // the staged loader write. Inside RUN the CPU owns the address and read strobe.
  always_comb begin
    state_d              = state_q;
    wr_ptr_d             = wr_ptr_q;
    load_count_d         = load_count_q;
    err_full_d           = err_full_q;
    hold_d               = '0;
    wr_en_d              = 1'b0;
    wr_addr_d            = wr_addr_q;
    wr_data_d            = wr_data_q;

    bus.ld_ready         = 1'b0;
    bus.cpu_reset        = 1'b1;
    bus.cpu_go           = 1'b0;
    bus.rom_write_enable = wr_en_q;
    bus.rom_addr         = wr_addr_q;
    bus.rom_wdata        = wr_data_q;
    bus.rom_read_enable  = 1'b0;
    done                 = 1'b0;

    unique case (state_q)
      IDLE, HALTED: begin
        done = (state_q == HALTED);
        if (start) begin
          state_d      = LOAD;
          wr_ptr_d     = '0;
          load_count_d = '0;
          err_full_d   = 1'b0;
        end
      end

      LOAD: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_valid) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = ptr_addr;
          wr_data_d    = bus.ld_data;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          load_count_d = load_count_q + 9'd1;
          // The last slot takes the final word, so no terminator fits.
          if (wr_ptr_q == LastPtr) begin
            state_d = RELEASE;
            if (!bus.ld_last) begin
              err_full_d = 1'b1;
            end
          end else if (bus.ld_last) begin
            state_d = TERM;
          end
        end
      end

      TERM: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_addr;
        wr_data_d = 32'h0;
        state_d   = RELEASE;
      end

      RELEASE: begin
        bus.cpu_go = 1'b1;
        hold_d     = hold_q + 4'd1;
        if (hold_q == HoldLast) begin
          hold_d  = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        bus.cpu_go           = 1'b1;
        bus.cpu_reset        = 1'b0;
        bus.rom_write_enable = 1'b0;
        bus.rom_addr         = bus.cpu_addr;
        bus.rom_read_enable  = bus.cpu_read_enable;
        if (bus.cpu_halt) begin
          state_d = HALTED;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rom_boot_ctrl
// Directed bench for rom_boot_ctrl (DEPTH=32, RESET_HOLD=2). The loader side
// is driven from one initial block. Every ROM write the controller should
// make is queued as {address, data} when the word is offered. Each clock
// tick compares the ROM write port against the head of that queue.
// ---------------------------------------------------------------------------
module tb_rom_boot_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] load_count;
  logic       err_full;
  logic       done;

  rom_boot_ctrl_if bus ();

  rom_boot_ctrl #(
    .DEPTH      (32),
    .RESET_HOLD (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .load_count (load_count),
    .err_full   (err_full),
    .done       (done)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nFail   = 0;
  int          ptr     = 0;
  logic [63:0] sb[$];

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the ROM write port against the scoreboard.
  // A write is due exactly when something was queued for this edge.
  task automatic tick();
    logic [63:0] e;
    @(posedge clk);
    #1;
    checkOutput("rom_write_enable", 32'(bus.rom_write_enable), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (bus.rom_write_enable) begin
        checkOutput("rom_addr", bus.rom_addr, e[63:32]);
        checkOutput("rom_wdata", bus.rom_wdata, e[31:0]);
      end
    end
  endtask

  // Offer one loader cycle. If the controller should accept it, queue the
  // write it must produce and advance the bench's own write pointer.
  task automatic applyStimulus(input logic valid, input logic [31:0] data,
                               input logic last, input bit accept);
    bus.ld_valid = valid;
    bus.ld_data  = data;
    bus.ld_last  = last;
    if (accept) begin
      sb.push_back({32'(ptr * 4), data});
      ptr++;
    end
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic queueTerminator();
    sb.push_back({32'(ptr * 4), 32'h0});
  endtask

  task automatic haltCpu();
    bus.cpu_halt = 1'b1;
    tick();
    bus.cpu_halt = 1'b0;
    checkOutput("halt_done", 32'(done), 32'd1);
    checkOutput("halt_cpu_go", 32'(bus.cpu_go), 32'd0);
  endtask

  task automatic startLoad();
    start = 1'b1;
    tick();
    start = 1'b0;
    ptr   = 0;
    checkOutput("load_ready", 32'(bus.ld_ready), 32'd1);
  endtask

  initial begin
    reset               = 1'b1;
    start               = 1'b0;
    bus.ld_valid        = 1'b0;
    bus.ld_data         = '0;
    bus.ld_last         = 1'b0;
    bus.cpu_addr        = '0;
    bus.cpu_read_enable = 1'b0;
    bus.cpu_halt        = 1'b0;

    // Reset state.
    tick();
    tick();
    checkOutput("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    checkOutput("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    checkOutput("rst_cpu_go", 32'(bus.cpu_go), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rom_addr", bus.rom_addr, 32'h0);
    checkOutput("rst_rom_wdata", bus.rom_wdata, 32'h0);
    checkOutput("rst_load_count", 32'(load_count), 32'd0);
    checkOutput("rst_err_full", 32'(err_full), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("idle_ld_ready", 32'(bus.ld_ready), 32'd0);

    // Three-word program, last on the third word, valid every cycle.
    startLoad();
    applyStimulus(1'b1, 32'hA000_0001, 1'b0, 1'b1);
    start = 1'b1;
    applyStimulus(1'b1, 32'hA000_0002, 1'b0, 1'b1);
    start = 1'b0;
    applyStimulus(1'b1, 32'hA000_0003, 1'b1, 1'b1);
    checkOutput("term_ld_ready", 32'(bus.ld_ready), 32'd0);
    queueTerminator();
    tick();
    checkOutput("rel1_cpu_go", 32'(bus.cpu_go), 32'd1);
    checkOutput("rel1_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    checkOutput("p3_load_count", 32'(load_count), 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("rel2_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    tick();
    checkOutput("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    checkOutput("run_cpu_go", 32'(bus.cpu_go), 32'd1);
    checkOutput("run_ld_ready", 32'(bus.ld_ready), 32'd0);

    // CPU fetch path is combinational while running.
    bus.cpu_addr        = 32'h10;
    bus.cpu_read_enable = 1'b1;
    #1;
    checkOutput("run_rom_addr", bus.rom_addr, 32'h10);
    checkOutput("run_rom_read_enable", 32'(bus.rom_read_enable), 32'd1);
    bus.cpu_read_enable = 1'b0;
    #1;
    checkOutput("run_rom_read_idle", 32'(bus.rom_read_enable), 32'd0);
    bus.cpu_read_enable = 1'b1;

    // Halt and start together: halt wins.
    start = 1'b1;
    haltCpu();
    start = 1'b0;
    checkOutput("halt_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    checkOutput("halt_ld_ready", 32'(bus.ld_ready), 32'd0);
    checkOutput("halt_rom_read_enable", 32'(bus.rom_read_enable), 32'd0);
    checkOutput("halt_rom_addr", bus.rom_addr, 32'd12);
    checkOutput("halt_load_count", 32'(load_count), 32'd3);
    bus.cpu_read_enable = 1'b0;
    tick();
    checkOutput("halt_stays", 32'(done), 32'd1);

    // Fill the whole ROM without ld_last: no terminator, sticky error.
    startLoad();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 1'b1);
    end
    checkOutput("full_err_full", 32'(err_full), 32'd1);
    checkOutput("full_load_count", 32'(load_count), 32'd32);
    checkOutput("full_cpu_go", 32'(bus.cpu_go), 32'd1);
    checkOutput("full_ld_ready", 32'(bus.ld_ready), 32'd0);
    tick();
    tick();
    checkOutput("full_run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    haltCpu();
    checkOutput("full_err_held", 32'(err_full), 32'd1);
    checkOutput("full_count_held", 32'(load_count), 32'd32);

    // Reload a two-word program from HALTED.
    startLoad();
    checkOutput("reload_err_cleared", 32'(err_full), 32'd0);
    checkOutput("reload_count_cleared", 32'(load_count), 32'd0);
    applyStimulus(1'b1, 32'hB000_0001, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'hB000_0002, 1'b1, 1'b1);
    queueTerminator();
    tick();
    tick();
    tick();
    checkOutput("reload_run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    checkOutput("reload_load_count", 32'(load_count), 32'd2);
    checkOutput("reload_err_full", 32'(err_full), 32'd0);
    haltCpu();

    // Gapped valid: writes only on handshakes; ld_last ignored without valid.
    startLoad();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hC000_0000 + 32'(i), (i == 3), 1'b1);
      if (i < 3) begin
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
      end
    end
    queueTerminator();
    applyStimulus(1'b1, 32'hBAD0_0BAD, 1'b1, 1'b0);
    checkOutput("gap_load_count", 32'(load_count), 32'd4);
    tick();
    tick();
    checkOutput("gap_run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    haltCpu();

    // Reset during the second handshake of a load: that write is dropped.
    startLoad();
    applyStimulus(1'b1, 32'hD000_0001, 1'b0, 1'b1);
    checkOutput("abort_count_before", 32'(load_count), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 32'hD000_0002, 1'b0, 1'b0);
    checkOutput("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
    checkOutput("abort_load_count", 32'(load_count), 32'd0);
    checkOutput("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    checkOutput("abort_cpu_go", 32'(bus.cpu_go), 32'd0);
    checkOutput("abort_rom_addr", bus.rom_addr, 32'h0);
    checkOutput("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();
    checkOutput("abort_idle_ld_ready", 32'(bus.ld_ready), 32'd0);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
